// File: rtl/tcam_pkg.sv
// Shared constants and loader state encoding for the TCAM rule loader.
package tcam_pkg;

  localparam int DATA_W = 36;
  localparam int ADDR_W = 2;
  localparam int BANKS  = 4;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int BANK_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CHECK = 3'd4,
    ST_CLEAR = 3'd5
  } state_t;

endpackage

// File: rtl/tcam_loader.sv
// Writes one rule word into a BRAM bank and verifies it by readback, or zeroes
// every bank; the lookup path is held off while either operation is in flight.
module tcam_loader
  import tcam_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [BANK_W-1:0]       req_bank,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_data,
  input  logic                    clr_start,
  output logic [BANKS-1:0]        bram_ena,
  output logic [BANKS-1:0]        bram_wea,
  output logic [ADDR_W-1:0]       bram_addr,
  output logic [DATA_W-1:0]       bram_din,
  input  logic [BANKS*DATA_W-1:0] bram_dout,
  output logic                    lookup_hold,
  output logic                    done,
  output logic                    done_err,
  output logic [7:0]              err_cnt,
  output state_t                  state_dbg
);

  state_t            state, state_nxt;
  logic              live;
  logic [BANK_W-1:0] bank_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q;
  logic              done_err_q;
  logic [7:0]        err_cnt_q;
  logic              accept;
  logic              clr_go;
  logic              clr_last;
  logic              mismatch;
  logic [BANKS-1:0]  bank_oh;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE (and not in the
  // first cycle after reset). A simultaneous clr_start takes priority and the
  // request is left pending. Request inputs are not looked at otherwise.
  assign clr_go   = (state == ST_IDLE) && live && clr_start;
  assign accept   = (state == ST_IDLE) && live && req_valid && !clr_start;
  assign clr_last = (clr_addr == ADDR_W'(DEPTH - 1));
  assign mismatch = (rdata_q != data_q);
  assign bank_oh  = BANKS'(1) << bank_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (clr_go)      state_nxt = ST_CLEAR;
        else if (accept) state_nxt = ST_WRITE;
      end
      ST_WRITE: state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = ST_IDLE;
      ST_CLEAR: if (clr_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      live       <= 1'b0;
      bank_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      clr_addr   <= '0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      if (accept) begin
        bank_q <= req_bank;
        addr_q <= req_addr;
        data_q <= req_data;
      end
      // Read data from the READ cycle is valid during WAIT.
      if (state == ST_WAIT) rdata_q <= bram_dout[bank_q*DATA_W +: DATA_W];
      clr_addr   <= (state == ST_CLEAR) ? clr_addr + 1'b1 : '0;
      done_q     <= (state == ST_CHECK) || ((state == ST_CLEAR) && clr_last);
      done_err_q <= (state == ST_CHECK) && mismatch;
      if ((state == ST_CHECK) && mismatch && (err_cnt_q != 8'hFF))
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  always_comb begin
    bram_ena  = '0;
    bram_wea  = '0;
    bram_addr = '0;
    bram_din  = '0;
    unique case (state)
      ST_WRITE: begin
        bram_ena  = bank_oh;
        bram_wea  = bank_oh;
        bram_addr = addr_q;
        bram_din  = data_q;
      end
      ST_READ: begin
        bram_ena  = bank_oh;
        bram_addr = addr_q;
      end
      ST_CLEAR: begin
        bram_ena  = '1;
        bram_wea  = '1;
        bram_addr = clr_addr;
      end
      default: ;
    endcase
  end

  assign req_ready   = live && (state == ST_IDLE);
  assign lookup_hold = (state != ST_IDLE);
  assign done        = done_q;
  assign done_err    = done_err_q;
  assign err_cnt     = err_cnt_q;
  assign state_dbg   = state;

endmodule
